// File: rtl/gf180mcu_ocd_io__ring_pwr_seq.sv
// gf180mcu_ocd_io__ring_pwr_seq
// Power/enable sequencer for the GF180 I/O ring. Debounces the I/O and core
// supply-good detectors, then releases pad isolation, input enable and output
// enable in that order. Tears them down in reverse order when the enable
// request drops, and forces immediate isolation when either supply is lost.
// Every output is a flop loaded from the next-state decode, so the pad
// controls change on the same edge as STATE and are never combinational.
module gf180mcu_ocd_io__ring_pwr_seq #(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DVDD_OK,
    input  logic       VDD_OK,
    input  logic       EN_REQ,
    output logic       ISO_N,
    output logic       IE_EN,
    output logic       OE_EN,
    output logic       READY,
    output logic       FAULT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_WAIT    = 3'd1,
        S_DEB     = 3'd2,
        S_REL_ISO = 3'd3,
        S_EN_IE   = 3'd4,
        S_RUN     = 3'd5,
        S_SD_OE   = 3'd6,
        S_SD_IE   = 3'd7
    } state_t;

    // Terminal counter values; a dwell of N cycles ends when cnt reaches N-1.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic             dvdd_meta;
    logic             dvdd_sync;
    logic             vdd_meta;
    logic             vdd_sync;
    logic             pg;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic             deb_done;
    logic             settle_done;
    logic             powered_state;
    logic             supply_loss;
    logic             counting;

    logic             iso_next;
    logic             ie_next;
    logic             oe_next;
    logic             ready_next;
    logic             fault_next;

    // Two-flop synchronisers for the asynchronous supply-good detectors
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dvdd_meta <= 1'b0;
            dvdd_sync <= 1'b0;
            vdd_meta  <= 1'b0;
            vdd_sync  <= 1'b0;
        end else begin
            dvdd_meta <= DVDD_OK;
            dvdd_sync <= dvdd_meta;
            vdd_meta  <= VDD_OK;
            vdd_sync  <= vdd_meta;
        end
    end

    assign pg          = dvdd_sync & vdd_sync;
    assign deb_done    = (cnt == DEB_LAST);
    assign settle_done = (cnt == SETTLE_LAST);

    // States 3..7 have released isolation at some point, so losing either
    // supply there must snap the pads back to isolation immediately.
    assign powered_state = state inside {S_REL_ISO, S_EN_IE, S_RUN, S_SD_OE, S_SD_IE};
    assign supply_loss   = powered_state & ~pg;

    // Only dwell states count; the others hold the counter at zero so it can
    // never wrap.
    assign counting = state inside {S_DEB, S_REL_ISO, S_EN_IE, S_SD_OE, S_SD_IE};

    // Next-state decode; supply loss overrides every other transition
    always_comb begin
        state_next = state;
        if (supply_loss) begin
            state_next = EN_REQ ? S_WAIT : S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    if (EN_REQ) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (!EN_REQ)  state_next = S_OFF;
                    else if (pg)  state_next = S_DEB;
                end
                S_DEB: begin
                    if (!EN_REQ)       state_next = S_OFF;
                    else if (!pg)      state_next = S_WAIT;
                    else if (deb_done) state_next = S_REL_ISO;
                end
                S_REL_ISO: begin
                    if (!EN_REQ)          state_next = S_SD_IE;
                    else if (settle_done) state_next = S_EN_IE;
                end
                S_EN_IE: begin
                    if (!EN_REQ)          state_next = S_SD_IE;
                    else if (settle_done) state_next = S_RUN;
                end
                S_RUN: begin
                    if (!EN_REQ) state_next = S_SD_OE;
                end
                S_SD_OE: begin
                    if (settle_done) state_next = S_SD_IE;
                end
                S_SD_IE: begin
                    if (settle_done) state_next = S_OFF;
                end
                default: state_next = S_OFF;
            endcase
        end
    end

    // Dwell counter: restarts on every state change, advances while holding
    always_comb begin
        cnt_next = '0;
        if ((state_next == state) && counting) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Pad-control decode of the state about to be entered
    always_comb begin
        iso_next   = 1'b0;
        ie_next    = 1'b0;
        oe_next    = 1'b0;
        ready_next = 1'b0;
        case (state_next)
            S_REL_ISO: begin
                iso_next = 1'b1;
            end
            S_EN_IE: begin
                iso_next = 1'b1;
                ie_next  = 1'b1;
            end
            S_RUN: begin
                iso_next   = 1'b1;
                ie_next    = 1'b1;
                oe_next    = 1'b1;
                ready_next = 1'b1;
            end
            S_SD_OE: begin
                iso_next = 1'b1;
                ie_next  = 1'b1;
            end
            S_SD_IE: begin
                iso_next = 1'b1;
            end
            default: begin
                iso_next   = 1'b0;
                ie_next    = 1'b0;
                oe_next    = 1'b0;
                ready_next = 1'b0;
            end
        endcase
    end

    // Sticky supply-loss flag: set wins, otherwise cleared while EN_REQ is low
    assign fault_next = supply_loss | (FAULT & EN_REQ);

    // State, counter and registered outputs all update on the same edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_OFF;
            cnt   <= '0;
            ISO_N <= 1'b0;
            IE_EN <= 1'b0;
            OE_EN <= 1'b0;
            READY <= 1'b0;
            FAULT <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ISO_N <= iso_next;
            IE_EN <= ie_next;
            OE_EN <= oe_next;
            READY <= ready_next;
            FAULT <= fault_next;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_gf180mcu_ocd_io__ring_pwr_seq.sv
// Testbench for gf180mcu_ocd_io__ring_pwr_seq (DEB_CYCLES=4, SETTLE_CYCLES=8).
// A table of timed vectors covers startup, shutdown, debounce glitch and
// shutdown-with-re-request; hand sequences cover supply loss and async reset;
// a random phase runs against a table-based reference model that is also
// checked on every cycle of every phase.
module tb_gf180mcu_ocd_io__ring_pwr_seq;

    localparam int DEB = 4;
    localparam int SET = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       DVDD_OK = 1'b0;
    logic       VDD_OK = 1'b0;
    logic       EN_REQ = 1'b0;
    logic       ISO_N;
    logic       IE_EN;
    logic       OE_EN;
    logic       READY;
    logic       FAULT;
    logic [2:0] STATE;

    int n_cmp = 0;
    int n_bad = 0;

    gf180mcu_ocd_io__ring_pwr_seq #(
        .DEB_CYCLES   (DEB),
        .SETTLE_CYCLES(SET),
        .CNT_W        (8)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DVDD_OK(DVDD_OK),
        .VDD_OK (VDD_OK),
        .EN_REQ (EN_REQ),
        .ISO_N  (ISO_N),
        .IE_EN  (IE_EN),
        .OE_EN  (OE_EN),
        .READY  (READY),
        .FAULT  (FAULT),
        .STATE  (STATE)
    );

    always #5 CLK = ~CLK;

    // ---------------------------------------------------------------
    // Reference model: per-state tables for dwell length, dwell exit,
    // and pad controls; pg taken from a two-deep history of the pins.
    // ---------------------------------------------------------------
    int       dwell_len  [8] = '{0, 0, DEB, SET, SET, 0, SET, SET};
    int       dwell_exit [8] = '{0, 0, 3, 4, 5, 5, 7, 0};
    bit [7:0] iso_map = 8'b1111_1000;
    bit [7:0] ie_map  = 8'b0111_0000;
    bit [7:0] oe_map  = 8'b0010_0000;

    int m_st;
    int m_age;
    bit m_fault;
    bit dv_h0, dv_h1, vd_h0, vd_h1;
    bit model_on = 1'b0;

    task automatic model_reset();
        m_st = 0; m_age = 0; m_fault = 0;
        dv_h0 = 0; dv_h1 = 0; vd_h0 = 0; vd_h1 = 0;
    endtask

    task automatic model_step();
        bit pg, en, loss, done;
        int nxt;
        pg   = dv_h1 & vd_h1;
        en   = EN_REQ;
        nxt  = m_st;
        loss = (m_st >= 3) && !pg;
        done = (dwell_len[m_st] > 0) && (m_age == dwell_len[m_st] - 1);
        if (loss) nxt = en ? 1 : 0;
        else if (m_st == 0) nxt = en ? 1 : 0;
        else if (m_st == 1) nxt = !en ? 0 : (pg ? 2 : 1);
        else if (m_st == 2) nxt = !en ? 0 : (!pg ? 1 : (done ? dwell_exit[2] : 2));
        else if (m_st == 3 || m_st == 4) nxt = !en ? 7 : (done ? dwell_exit[m_st] : m_st);
        else if (m_st == 5) nxt = !en ? 6 : 5;
        else nxt = done ? dwell_exit[m_st] : m_st;
        m_age   = (nxt != m_st) ? 0 : m_age + 1;
        m_st    = nxt;
        m_fault = loss ? 1'b1 : (en ? m_fault : 1'b0);
        dv_h1 = dv_h0; dv_h0 = DVDD_OK;
        vd_h1 = vd_h0; vd_h0 = VDD_OK;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) model_reset();
        else     model_step();
    end

    task automatic check_outs(input string name, input int st, input bit iso, input bit ie,
                              input bit oe, input bit rdy, input bit flt);
        n_cmp++;
        if ({STATE, ISO_N, IE_EN, OE_EN, READY, FAULT} !== {st[2:0], iso, ie, oe, rdy, flt}) begin
            n_bad++;
            $display("FAIL %s @%0t: got st=%0d iso=%b ie=%b oe=%b rdy=%b flt=%b, expected st=%0d iso=%b ie=%b oe=%b rdy=%b flt=%b",
                     name, $time, STATE, ISO_N, IE_EN, OE_EN, READY, FAULT,
                     st, iso, ie, oe, rdy, flt);
        end
    endtask

    // Per-cycle model comparison and ordering invariant
    always @(posedge CLK) begin
        #1;
        if (model_on && !RST) begin
            check_outs("model", m_st, iso_map[m_st], ie_map[m_st], oe_map[m_st],
                       m_st == 5, m_fault);
            n_cmp++;
            if ((OE_EN && !IE_EN) || (IE_EN && !ISO_N)) begin
                n_bad++;
                $display("FAIL invariant @%0t: iso=%b ie=%b oe=%b, required oe->ie->iso",
                         $time, ISO_N, IE_EN, OE_EN);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    typedef struct {
        bit rst;
        bit en, dv, vd;
        int n;
        int st;
        bit iso, ie, oe, rdy, flt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit en, input bit dv, input bit vd, input int n,
                       input int st, input bit iso, input bit ie, input bit oe,
                       input bit rdy, input bit flt);
        vec_t v;
        v.rst = rst; v.en = en; v.dv = dv; v.vd = vd; v.n = n;
        v.st = st; v.iso = iso; v.ie = ie; v.oe = oe; v.rdy = rdy; v.flt = flt;
        vecs.push_back(v);
    endtask

    // Reset with pins already good so the synchronisers fill right after release
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; EN_REQ = 1'b0; DVDD_OK = 1'b1; VDD_OK = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drive inputs at the falling edge, advance n rising edges, sample 1ns later
    task automatic step(input bit en, input bit dv, input bit vd, input int n);
        @(negedge CLK);
        EN_REQ = en; DVDD_OK = dv; VDD_OK = vd;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic reach_run();
        int waited;
        do_reset();
        step(0, 1, 1, 2);
        step(1, 1, 1, 1);
        waited = 0;
        while (!READY && waited < 100) begin
            @(posedge CLK); #1;
            waited++;
        end
        check_outs("reach_run", 5, 1, 1, 1, 1, 0);
    endtask

    // ---------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------
    initial begin
        int cyc, last_wait, ready_at;
        model_reset();

        //  rst en dv vd  n   st iso ie oe rdy flt
        // startup: EN_REQ first sampled at edge 0 -> ISO@5, IE@13, RUN@21
        add(1, 0, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 3,  2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  3, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 7,  3, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  4, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 7,  4, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1,  5, 1, 1, 1, 1, 0);
        add(0, 1, 1, 1, 5,  5, 1, 1, 1, 1, 0);
        // shutdown: EN_REQ low sampled at t -> OE off @t, IE off @t+8, OFF @t+16
        add(0, 0, 1, 1, 1,  6, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 7,  6, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1,  7, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 7,  7, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        // one-cycle DVDD_OK glitch during DEB: back to WAIT, debounce restarts
        add(1, 0, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 2,  2, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1,  2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 2,  1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 3,  2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  3, 1, 0, 0, 0, 0);
        // EN_REQ drops in EN_IE, re-requested during SD_IE: 4 -> 7 -> 0 -> 1
        add(1, 0, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 14, 4, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1,  7, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 6,  7, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  7, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0);

        model_on = 1'b1;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].en, vecs[i].dv, vecs[i].vd, vecs[i].n);
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].iso, vecs[i].ie,
                       vecs[i].oe, vecs[i].rdy, vecs[i].flt);
        end

        // Supply loss in RUN: VDD_OK pin drops just after edge t
        reach_run();
        VDD_OK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_outs("loss_t+2", 5, 1, 1, 1, 1, 0);
        @(posedge CLK); #1;
        check_outs("loss_t+3", 1, 0, 0, 0, 0, 1);
        VDD_OK = 1'b1;
        cyc = 0; last_wait = -1; ready_at = -1;
        while (ready_at < 0 && cyc < 80) begin
            @(posedge CLK); #1;
            cyc++;
            if (STATE == 3'd1) last_wait = cyc;
            if (READY) ready_at = cyc;
        end
        n_cmp++;
        if (ready_at < 0 || last_wait < 0 || ready_at - last_wait != 21) begin
            n_bad++;
            $display("FAIL loss_recover: READY %0d cycles after last WAIT cycle (ready_at=%0d), expected 21",
                     ready_at - last_wait, ready_at);
        end
        check_outs("loss_fault_sticky", 5, 1, 1, 1, 1, 1);
        step(0, 1, 1, 1);
        check_outs("loss_fault_clear", 6, 1, 1, 0, 0, 0);

        // Asynchronous reset mid-RUN, between clock edges
        reach_run();
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Random phase against the reference model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if ($urandom_range(39, 0) == 0) EN_REQ = ~EN_REQ;
            if (DVDD_OK) DVDD_OK = ($urandom_range(149, 0) != 0);
            else         DVDD_OK = ($urandom_range(2, 0) == 0);
            if (VDD_OK)  VDD_OK  = ($urandom_range(149, 0) != 0);
            else         VDD_OK  = ($urandom_range(2, 0) == 0);
        end
        @(posedge CLK); #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
